// File: rtl/seq_store.sv
// Append-only colour sequence store with autonomous playback and a registered random-access read port.
// Optional macro PLAY_READY_EN adds a play_ready handshake input that stalls playback.
module seq_store #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              append,
  input  logic [DATA_W-1:0] append_data,
  output logic [ADDR_W:0]   length,
  output logic              full,
  input  logic              play_start,
`ifdef PLAY_READY_EN
  input  logic              play_ready,
`endif
  output logic              play_busy,
  output logic              play_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              play_last,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]     length_q, length_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                full_q, full_d;
  logic                play_valid_q, play_valid_d;
  logic                play_last_q, play_last_d;
  logic [DATA_W-1:0]   play_data_q;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic                ready;
  logic                start_ok, append_ok, rd_ok, handshake, rd_in_range;
  logic                fetch;
  logic [ADDR_W-1:0]   fetch_addr;

`ifdef PLAY_READY_EN
  assign ready = play_ready;
`else
  assign ready = 1'b1;
`endif

  // A request is only honoured in IDLE; an accepted play_start swallows a concurrent append.
  assign start_ok    = !clear && (state_q == IDLE) && play_start && (length_q != '0);
  assign append_ok   = !clear && (state_q == IDLE) && append && !full_q && !start_ok;
  assign rd_ok       = !clear && (state_q == IDLE) && rd_en;
  assign handshake   = (state_q == PLAY) && play_valid_q && ready;
  assign rd_in_range = {1'b0, rd_addr} < length_q;

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    ptr_d        = ptr_q;
    play_valid_d = play_valid_q;
    play_last_d  = play_last_q;
    fetch        = 1'b0;
    fetch_addr   = '0;
    if (clear) begin
      state_d      = IDLE;
      length_d     = '0;
      play_valid_d = 1'b0;
      play_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_d      = PLAY;
            fetch        = 1'b1;
            fetch_addr   = '0;
            ptr_d        = ONE_L;
            play_valid_d = 1'b1;
            play_last_d  = (length_q == ONE_L);
          end else if (append_ok) begin
            length_d = length_q + ONE_L;
          end
        end
        PLAY: begin
          if (handshake) begin
            if (play_last_q) begin
              state_d      = IDLE;
              play_valid_d = 1'b0;
              play_last_d  = 1'b0;
            end else begin
              fetch       = 1'b1;
              fetch_addr  = ptr_q[ADDR_W-1:0];
              ptr_d       = ptr_q + ONE_L;
              play_last_d = (ptr_q == length_q - ONE_L);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    full_d     = (length_d == DEPTH_L);
    rd_valid_d = rd_ok;
    rd_err_d   = rd_ok ? !rd_in_range : rd_err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      length_q     <= '0;
      ptr_q        <= '0;
      full_q       <= 1'b0;
      play_valid_q <= 1'b0;
      play_last_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      ptr_q        <= ptr_d;
      full_q       <= full_d;
      play_valid_q <= play_valid_d;
      play_last_q  <= play_last_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Storage is left uninitialised: entries at or beyond length are never observable.
  always_ff @(posedge clock) begin
    if (append_ok) mem[length_q[ADDR_W-1:0]] <= append_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      play_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      if (fetch) play_data_q <= mem[fetch_addr];
      if (rd_ok) rd_data_q   <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  assign length     = length_q;
  assign full       = full_q;
  assign play_busy  = (state_q == PLAY);
  assign play_valid = play_valid_q;
  assign play_last  = play_last_q;
  assign play_data  = play_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_seq_store.sv
// Randomised scoreboard bench for seq_store: a queue-based sequence model predicts playback and read responses.
module tb_seq_store;
  localparam int DATA_W = 2;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef PLAY_READY_EN
  localparam bit HAS_READY = 1'b1;
`else
  localparam bit HAS_READY = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, clear, append, play_start, rd_en, play_ready;
  logic [DATA_W-1:0] append_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   length;
  logic full, play_busy, play_valid, play_last, rd_valid, rd_err;
  logic [DATA_W-1:0] play_data, rd_data;

  seq_store #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear), .append(append), .append_data(append_data),
    .length(length), .full(full), .play_start(play_start),
`ifdef PLAY_READY_EN
    .play_ready(play_ready),
`endif
    .play_busy(play_busy), .play_valid(play_valid), .play_data(play_data), .play_last(play_last),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int data;
    int flag;
    int cyc;
  } exp_t;

  exp_t pq[$];
  exp_t rq[$];
  int   seq[$];
  bit   playing;
  int   pos;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pop one expectation for every presented output and compare content and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (play_valid) begin
        if (pq.size() == 0) chk("play_unexpected", 1, 0);
        else begin
          e = pq.pop_front();
          chk("play_data", int'(play_data), e.data);
          chk("play_last", int'(play_last), e.flag);
          chk("play_cycle", cyc, e.cyc);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rd_data", int'(rd_data), e.data);
          chk("rd_err", int'(rd_err), e.flag);
          chk("rd_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts what appears after the coming edge.
  task automatic step(input bit clr, input bit app, input int ad, input bit ps,
                      input bit re, input int ra, input bit rdy);
    int  len;
    bit  r;
    r   = HAS_READY ? rdy : 1'b1;
    len = seq.size();
    clear = clr; append = app; append_data = DATA_W'(ad);
    play_start = ps; rd_en = re; rd_addr = ADDR_W'(ra); play_ready = r;
    if (clr) begin
      seq.delete();
      playing = 1'b0;
    end else if (playing) begin
      if (r) begin
        if (pos == len - 1) playing = 1'b0;
        else begin
          pos++;
          pq.push_back('{seq[pos], int'(pos == len - 1), cyc + 1});
        end
      end else begin
        pq.push_back('{seq[pos], int'(pos == len - 1), cyc + 1});
      end
    end else begin
      if (re) rq.push_back('{(ra < len) ? seq[ra] : 0, int'(ra >= len), cyc + 1});
      if (ps && len > 0) begin
        playing = 1'b1;
        pos = 0;
        pq.push_back('{seq[0], int'(len == 1), cyc + 1});
      end else if (app && len < DEPTH) begin
        seq.push_back(ad);
      end
    end
    @(posedge clock);
    #1;
    chk("length", int'(length), seq.size());
    chk("full", int'(full), int'(seq.size() == DEPTH));
    chk("play_busy", int'(play_busy), int'(playing));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int d;
    reset = 1'b1; clear = 0; append = 0; append_data = '0;
    play_start = 0; rd_en = 0; rd_addr = '0; play_ready = 1'b1;
    playing = 1'b0; pos = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_length", int'(length), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(play_busy), 0);
    chk("rst_play_valid", int'(play_valid), 0);
    chk("rst_play_last", int'(play_last), 0);
    chk("rst_play_data", int'(play_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_err", int'(rd_err), 0);
    reset = 1'b0;

    // Known sequence, read-back, playback, out-of-range read.
    step(0, 1, 2, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 2, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(5);
    step(0, 0, 0, 0, 1, 5, 1);
    // Same-cycle read and append at index == length reports an error.
    step(0, 1, 2, 0, 1, 4, 1);
    // Play and append together: append dropped.
    step(0, 1, 3, 1, 0, 0, 1);
    idle(7);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(2);

    // Fill to capacity plus one rejected append, then check last slot and play all.
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, $urandom_range(0, 3), 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, DEPTH - 1, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(DEPTH + 2);

    // Clear during the second playback entry, then restart appends at index 0.
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      d = $urandom_range(0, 99);
      step(d < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, DEPTH - 1), $urandom_range(0, 9) > 2);
    end
    idle(DEPTH + 4);
    chk("play_queue_drained", pq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
